// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for pipe_stage_buf: upstream push side and downstream pop side.
// master = producer/consumer environment, slave = the buffer itself.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 64
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic 2-entry skid-buffered pipeline stage with flush, bubble/hold stall and NOP payload.
// Optional stall/flush performance counters are enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE  = '0,
  parameter int                STALL_MODE = 0,
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_buf_if.slave   bus,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              bubble_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              holding;
  logic              state_bad;
  logic              push;
  logic              pop;

  assign holding   = (state == ST_ONE) || (state == ST_TWO);
  assign state_bad = (state == 2'd3);

  // Upstream ready never looks at out_ready_i, which is what breaks the ready chain.
  assign bus.in_ready_o = (state != ST_TWO) && !stall_i && !flush_i;
  assign push           = bus.in_valid_i && bus.in_ready_o;
  assign pop            = holding && bus.out_ready_i && !stall_i && !flush_i;
  assign occupancy_o    = state;

  always_comb begin
    bus.out_valid_o = holding;
    bus.out_data_o  = main_q;
    bubble_o        = 1'b0;
    if (stall_i && (STALL_MODE == 0)) begin
      bus.out_valid_o = 1'b0;
      bus.out_data_o  = NOP_VALUE;
      bubble_o        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (flush_i || state_bad) begin
      state  <= ST_EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (!stall_i) begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            state  <= ST_ONE;
            main_q <= bus.in_data_i;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_q <= bus.in_data_i;
          end else if (push) begin
            state  <= ST_TWO;
            skid_q <= bus.in_data_i;
          end else if (pop) begin
            state  <= ST_EMPTY;
            main_q <= NOP_VALUE;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state  <= ST_ONE;
            main_q <= skid_q;
            skid_q <= NOP_VALUE;
          end
        end
        default: begin
          state  <= ST_EMPTY;
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating counters; flush_i deliberately leaves them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_i && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_i && (state != ST_EMPTY) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
